pong_match_ctrl: RTL

//  Match-level FSM for Pong: sequences start/serve/play/pause/done, keeps both scores and picks the server.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/pong_match_ctrl_if.sv | 24 ++
 rtl/pong_serve_timer.sv | 29 ++
 rtl/pong_match_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared codes for the Pong match controller and its neighbours.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'b000,
    ST_SERVE = 3'b001,
    ST_PLAY  = 3'b010,
    ST_PAUSE = 3'b011,
    ST_DONE  = 3'b100
  } state_e;

  localparam logic [1:0] BALL_PLAYING = 2'b00;
  localparam logic [1:0] BALL_P1WIN   = 2'b01;
  localparam logic [1:0] BALL_P2WIN   = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Bundle between physics/keys (master) and the match controller (slave).
interface pong_match_ctrl_if #(
  parameter int unsigned SCORE_W = 4
);
  logic [1:0]         ballStatus;
  logic               enter;
  logic               pause;
  logic [2:0]         state;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               server;
  logic [1:0]         winner;
  logic               point;

  modport master (
    output ballStatus, enter, pause,
    input  state, score1, score2, server, winner, point
  );

  modport slave (
    input  ballStatus, enter, pause,
    output state, score1, score2, server, winner, point
  );
endinterface

// File: rtl/pong_serve_timer.sv
// Counts cycles spent in SERVE and flags when the automatic serve is due.
module pong_serve_timer #(
  parameter int unsigned TMR_W      = 24,
  parameter int unsigned AUTO_SERVE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = (AUTO_SERVE == 0) ? '0 : TMR_W'(AUTO_SERVE - 1);

  logic [TMR_W-1:0] cnt;

  // Cleared outside SERVE and on the exit edge; counts while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  // A zero timeout means the feature is disabled entirely.
  assign expire = (AUTO_SERVE != 0) && (cnt == LAST);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level FSM for Pong: serve/play/pause/done sequencing, scores, server, winner.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCORE_W    = 4,
  parameter int unsigned WIN_SCORE  = 11,
  parameter int unsigned WIN_BY_TWO = 1,
  parameter int unsigned AUTO_SERVE = 0,
  parameter int unsigned TMR_W      = 24
) (
  input logic             clk,
  input logic             rst,
  pong_match_ctrl_if.slave bus
);

  localparam int unsigned       SW1       = SCORE_W + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e             st;
  logic [SCORE_W-1:0] score1_q;
  logic [SCORE_W-1:0] score2_q;
  logic               server_q;
  logic [1:0]         winner_q;
  logic               point_q;

  logic [SCORE_W-1:0] s1_inc;
  logic [SCORE_W-1:0] s2_inc;
  logic               p1_scores;
  logic               p2_scores;
  logic               p1_wins;
  logic               p2_wins;
  logic               go_play;
  logic               expire;
  logic               tmr_clr;
  logic               tmr_en;

  // Win test at one extra bit so o+2 cannot wrap; a saturated score always wins.
  function automatic logic wins(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] o);
    logic [SW1-1:0] s_x;
    logic [SW1-1:0] o_x;
    s_x = SW1'(s);
    o_x = SW1'(o);
    return (s_x >= SW1'(WIN_SCORE)) &&
           ((WIN_BY_TWO == 0) || (s_x >= o_x + SW1'(2)) || (s == SCORE_MAX));
  endfunction

  pong_serve_timer #(
    .TMR_W      (TMR_W),
    .AUTO_SERVE (AUTO_SERVE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  // Saturating increments, scoring decode and serve trigger.
  always_comb begin
    s1_inc    = (score1_q == SCORE_MAX) ? score1_q : score1_q + SCORE_W'(1);
    s2_inc    = (score2_q == SCORE_MAX) ? score2_q : score2_q + SCORE_W'(1);
    p1_scores = (st == ST_PLAY) && (bus.ballStatus == BALL_P1WIN);
    p2_scores = (st == ST_PLAY) && (bus.ballStatus == BALL_P2WIN);
    p1_wins   = wins(s1_inc, score2_q);
    p2_wins   = wins(s2_inc, score1_q);
    go_play   = (st == ST_SERVE) && (bus.enter || expire);
    tmr_en    = (st == ST_SERVE);
    tmr_clr   = (st != ST_SERVE) || go_play;
  end

  // Match FSM with registered scores, server, winner and point strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_START;
      score1_q <= '0;
      score2_q <= '0;
      server_q <= 1'b0;
      winner_q <= WIN_NONE;
      point_q  <= 1'b0;
    end else begin
      point_q <= 1'b0;
      case (st)
        ST_START: begin
          st       <= ST_SERVE;
          score1_q <= '0;
          score2_q <= '0;
          winner_q <= WIN_NONE;
          point_q  <= (score1_q != '0) || (score2_q != '0);
        end
        ST_SERVE: begin
          if (go_play) st <= ST_PLAY;
        end
        ST_PLAY: begin
          if (p1_scores) begin
            score1_q <= s1_inc;
            server_q <= 1'b1;
            point_q  <= (s1_inc != score1_q);
            if (p1_wins) begin
              st       <= ST_DONE;
              winner_q <= WIN_P1;
            end else begin
              st <= ST_SERVE;
            end
          end else if (p2_scores) begin
            score2_q <= s2_inc;
            server_q <= 1'b0;
            point_q  <= (s2_inc != score2_q);
            if (p2_wins) begin
              st       <= ST_DONE;
              winner_q <= WIN_P2;
            end else begin
              st <= ST_SERVE;
            end
          end else if (bus.pause) begin
            st <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (bus.pause) st <= ST_PLAY;
        end
        ST_DONE: begin
          if (bus.enter) st <= ST_START;
        end
        default: st <= ST_START;
      endcase
    end
  end

  assign bus.state  = st;
  assign bus.score1 = score1_q;
  assign bus.score2 = score2_q;
  assign bus.server = server_q;
  assign bus.winner = winner_q;
  assign bus.point  = point_q;

endmodule
